spi_flash_controller: RTL and testbench



---
 rtl/spi_flash_controller.sv | 218 +++++++++++++++++++++
 tb/tb_spi_flash_controller.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_controller.sv
// SPI mode-0 flash master: one transaction per start (opcode, optional 24-bit address, optional data).
// Optional DUMMY_CYCLES_EN adds a dummy_en port and an 8-sclk DUMMY phase for fast-read style commands.
module spi_flash_controller #(
  parameter int CLK_DIV = 2,
  parameter int LEN_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       opcode,
  input  logic [23:0]      addr,
  input  logic             has_addr,
  input  logic [LEN_W-1:0] length,
  input  logic             read_write,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic             busy,
  output logic             done,
  output logic [2:0]       phase,
  output logic             sclk,
  output logic             cs_n,
  output logic             mosi,
`ifdef DUMMY_CYCLES_EN
  input  logic             dummy_en,
`endif
  input  logic             miso
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] HALF_M1 = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] GAP_M1  = DIV_W'(2 * CLK_DIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CS_SETUP = 3'd1,
    ST_CMD      = 3'd2,
    ST_ADDR     = 3'd3,
    ST_DATA     = 3'd4,
    ST_CS_HOLD  = 3'd5,
    ST_CS_GAP   = 3'd6
`ifdef DUMMY_CYCLES_EN
    , ST_DUMMY  = 3'd7
`endif
  } state_e;

  state_e           state_q;
  state_e           hdr_next_d;
  logic [DIV_W-1:0] div_q;
  logic [4:0]       bit_q;
  logic [LEN_W-1:0] byte_q;
  logic [23:0]      sr_q;
  logic [6:0]       rx_sh_q;
  logic [23:0]      addr_q;
  logic             has_addr_q;
  logic             rd_q;
  logic             loaded_q;
  logic             sclk_q;
  logic             cs_n_q;
  logic             mosi_q;
  logic             busy_q;
  logic             done_q;
  logic             tx_ready_q;
  logic             rx_valid_q;
  logic [7:0]       rx_data_q;
`ifdef DUMMY_CYCLES_EN
  logic             dummy_q;
`endif

  // Phase that follows the end of CMD, ADDR or DUMMY.
  always_comb begin
    hdr_next_d = ST_CS_HOLD;
    if (state_q == ST_CMD && has_addr_q)
      hdr_next_d = ST_ADDR;
`ifdef DUMMY_CYCLES_EN
    else if (state_q != ST_DUMMY && dummy_q)
      hdr_next_d = ST_DUMMY;
`endif
    else if (byte_q != '0)
      hdr_next_d = ST_DATA;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      byte_q     <= '0;
      sr_q       <= '0;
      rx_sh_q    <= '0;
      addr_q     <= '0;
      has_addr_q <= 1'b0;
      rd_q       <= 1'b0;
      loaded_q   <= 1'b0;
      sclk_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tx_ready_q <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
`ifdef DUMMY_CYCLES_EN
      dummy_q    <= 1'b0;
`endif
    end else begin
      tx_ready_q <= 1'b0;
      rx_valid_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            addr_q     <= addr;
            has_addr_q <= has_addr;
            byte_q     <= length;
            rd_q       <= read_write;
`ifdef DUMMY_CYCLES_EN
            dummy_q    <= dummy_en;
`endif
            sr_q       <= {opcode, 16'h0000};
            mosi_q     <= opcode[7];
            bit_q      <= 5'd7;
            div_q      <= '0;
            cs_n_q     <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= ST_CS_SETUP;
          end
        end
        ST_CS_SETUP: begin
          if (div_q == HALF_M1) begin
            div_q   <= '0;
            state_q <= ST_CMD;
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        ST_CMD, ST_ADDR,
`ifdef DUMMY_CYCLES_EN
        ST_DUMMY,
`endif
        ST_DATA: begin
          if (state_q == ST_DATA && !rd_q && !loaded_q) begin
            // Write byte boundary: sclk stays low until the next byte is offered.
            if (tx_valid) begin
              tx_ready_q <= 1'b1;
              sr_q       <= {tx_data, 16'h0000};
              mosi_q     <= tx_data[7];
              loaded_q   <= 1'b1;
              div_q      <= '0;
            end
          end else if (div_q != HALF_M1) begin
            div_q <= div_q + 1'b1;
          end else begin
            div_q  <= '0;
            sclk_q <= ~sclk_q;
            if (!sclk_q) begin
              rx_sh_q <= {rx_sh_q[5:0], miso};
              if (state_q == ST_DATA && rd_q && bit_q == 5'd0) begin
                rx_data_q  <= {rx_sh_q, miso};
                rx_valid_q <= 1'b1;
              end
            end else if (bit_q != 5'd0) begin
              bit_q  <= bit_q - 1'b1;
              sr_q   <= sr_q << 1;
              mosi_q <= sr_q[22];
            end else if (state_q == ST_DATA) begin
              byte_q   <= byte_q - 1'b1;
              bit_q    <= 5'd7;
              loaded_q <= 1'b0;
              mosi_q   <= 1'b0;
              if (byte_q == LEN_W'(1))
                state_q <= ST_CS_HOLD;
            end else begin
              state_q  <= hdr_next_d;
              loaded_q <= 1'b0;
              bit_q    <= (hdr_next_d == ST_ADDR) ? 5'd23 : 5'd7;
              sr_q     <= (hdr_next_d == ST_ADDR) ? addr_q : 24'h000000;
              mosi_q   <= (hdr_next_d == ST_ADDR) ? addr_q[23] : 1'b0;
            end
          end
        end
        ST_CS_HOLD: begin
          if (div_q == HALF_M1) begin
            div_q   <= '0;
            cs_n_q  <= 1'b1;
            state_q <= ST_CS_GAP;
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        ST_CS_GAP: begin
          if (div_q == GAP_M1) begin
            div_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign tx_ready = tx_ready_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign phase    = state_q;
  assign sclk     = sclk_q;
  assign cs_n     = cs_n_q;
  assign mosi     = mosi_q;

endmodule

// File: tb/tb_spi_flash_controller.sv
// Self-checking bench for spi_flash_controller: directed flash commands plus randomized transactions.
module tb_spi_flash_controller;
  localparam int CLK_DIV = 2;
  localparam int LEN_W   = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic [7:0]       opcode = 8'h00;
  logic [23:0]      addr = 24'h0;
  logic             has_addr = 1'b0;
  logic [LEN_W-1:0] length = '0;
  logic             read_write = 1'b0;
  logic [7:0]       tx_data = 8'h00;
  logic             tx_valid = 1'b0;
  logic             tx_ready;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             busy;
  logic             done;
  logic [2:0]       phase;
  logic             sclk;
  logic             cs_n;
  logic             mosi;
  logic             miso;
`ifdef DUMMY_CYCLES_EN
  logic             dummy_en = 1'b0;
`endif

  int tests_run = 0;
  int fail_cnt  = 0;

  // Flash-side view: bit i of a stream is the i-th bit on the wire.
  logic [511:0] miso_stream = '0;
  logic [511:0] mosi_seen   = '0;
  logic [7:0]   tx_bytes[16];
  logic [7:0]   rx_seen[$];
  int rise_cnt = 0, txr_cnt = 0, done_cnt = 0, cs_low_cnt = 0, gap_cnt = 0, bad_edge = 0;
  logic sclk_prev = 1'b0;

  spi_flash_controller #(.CLK_DIV(CLK_DIV), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .addr(addr),
    .has_addr(has_addr), .length(length), .read_write(read_write),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .done(done),
    .phase(phase), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
`ifdef DUMMY_CYCLES_EN
    .dummy_en(dummy_en),
`endif
    .miso(miso)
  );

  always #5 clk = ~clk;

  assign miso = miso_stream[rise_cnt[8:0]];

  always @(negedge clk) begin
    if (sclk && !sclk_prev) begin
      if (rise_cnt < 512) mosi_seen[rise_cnt[8:0]] = mosi;
      if (cs_n) bad_edge++;
      rise_cnt++;
    end
    sclk_prev = sclk;
    if (rx_valid) rx_seen.push_back(rx_data);
    if (tx_ready) txr_cnt++;
    if (done) done_cnt++;
    if (!cs_n) cs_low_cnt++;
    if (cs_n && busy) gap_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_stream(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs[159:0], exp[159:0]);
    end
  endtask

  task automatic randomize_miso();
    for (int i = 0; i < 16; i++) miso_stream[i*32 +: 32] = $urandom;
  endtask

  // One complete transaction; expectations come from the wire-level rules of the command.
  task automatic run_txn(input logic [7:0] op, input logic [23:0] a, input bit ha, input int len,
                         input bit rw, input int stall_cyc, input bit inject_start);
    logic [511:0] exp_bits;
    logic [7:0]   exp_rx;
    int nb, hdr, txi, stall_left, base_low;
    bit fin;
    exp_bits = '0;
    nb = 0;
    for (int i = 7; i >= 0; i--) begin exp_bits[nb] = op[i]; nb++; end
    if (ha) for (int i = 23; i >= 0; i--) begin exp_bits[nb] = a[i]; nb++; end
    hdr = nb;
    for (int k = 0; k < len; k++)
      for (int i = 7; i >= 0; i--) begin exp_bits[nb] = rw ? 1'b0 : tx_bytes[k][i]; nb++; end
    base_low = 2 * CLK_DIV * nb + 2 * CLK_DIV;

    @(posedge clk); #1;
    rise_cnt = 0; mosi_seen = '0; rx_seen.delete();
    txr_cnt = 0; done_cnt = 0; cs_low_cnt = 0; gap_cnt = 0; bad_edge = 0;

    @(negedge clk);
    opcode = op; addr = a; has_addr = ha; length = len[LEN_W-1:0]; read_write = rw;
    txi = 0; stall_left = 0;
    tx_data = tx_bytes[0];
    tx_valid = !rw && len > 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    fin = 1'b0;
    for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
      if (tx_ready) begin
        txi++;
        if (stall_cyc > 0 && txi == 1) stall_left = stall_cyc;
      end
      if (stall_left > 0) begin
        stall_left--;
        if (stall_left < 8) chk("stall_idle", {cs_n, sclk}, 2'b00);
      end
      tx_valid = !rw && txi < len && stall_left == 0;
      tx_data  = (txi < len) ? tx_bytes[txi] : 8'h00;
      if (inject_start && cyc == 20) begin
        opcode = 8'h9F; has_addr = 1'b0; length = '0; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) fin = 1'b1;
      else @(negedge clk);
    end
    start = 1'b0;
    tx_valid = 1'b0;
    chk("done_seen", fin, 1'b1);
    repeat (inject_start ? 100 : 30) @(negedge clk);

    chk("sclk_rises", rise_cnt, nb);
    chk_stream("mosi_stream", mosi_seen, exp_bits);
    chk("edge_cs_high", bad_edge, 0);
    chk("tx_ready_cnt", txr_cnt, rw ? 0 : len);
    chk("rx_valid_cnt", rx_seen.size(), rw ? len : 0);
    for (int k = 0; k < rx_seen.size() && k < len; k++) begin
      exp_rx = '0;
      for (int i = 0; i < 8; i++) exp_rx = {exp_rx[6:0], miso_stream[hdr + 8*k + i]};
      chk("rx_byte", rx_seen[k], exp_rx);
    end
    chk("done_cnt", done_cnt, 1);
    chk("cs_gap_cycles", gap_cnt, 2 * CLK_DIV);
    if (rw || len == 0) chk("cs_low_cycles", cs_low_cnt, base_low);
    else                chk("cs_low_min", cs_low_cnt >= base_low + stall_cyc - 16 * CLK_DIV - 2, 1'b1);
    chk("idle_state", {busy, phase, cs_n, sclk}, {1'b0, 3'd0, 1'b1, 1'b0});
    $display("[TB] txn op=%02h addr=%06h ha=%0d len=%0d rd=%0d rises=%0d rx=%0d txr=%0d",
             op, a, ha, len, rw, rise_cnt, rx_seen.size(), txr_cnt);
  endtask

  initial begin
    logic [7:0] rxb;
    logic [23:0] ra;
    bit got_addr;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_outputs", {cs_n, sclk, mosi, busy, done, tx_ready, rx_valid},
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_phase", phase, 3'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Write enable: opcode only.
    randomize_miso();
    run_txn(8'h06, 24'h000000, 1'b0, 0, 1'b0, 0, 1'b0);

    // Status read returning 0x03.
    randomize_miso();
    rxb = 8'h03;
    for (int i = 0; i < 8; i++) miso_stream[8 + i] = rxb[7 - i];
    run_txn(8'h05, 24'h000000, 1'b0, 1, 1'b1, 0, 1'b0);
    chk("status_byte", (rx_seen.size() > 0) ? rx_seen[0] : 8'hxx, 8'h03);

    // Page program, then the same with the second byte withheld.
    tx_bytes[0] = 8'hA5; tx_bytes[1] = 8'h5A;
    run_txn(8'h02, 24'h001234, 1'b1, 2, 1'b0, 0, 1'b0);
    run_txn(8'h02, 24'h001234, 1'b1, 2, 1'b0, 16 * CLK_DIV + 10, 1'b0);

    // start while busy must be ignored.
    randomize_miso();
    run_txn(8'h0B, 24'hABCDEF, 1'b1, 2, 1'b1, 0, 1'b1);

    // Asynchronous reset in the middle of the address phase.
    @(negedge clk);
    opcode = 8'h03; addr = 24'h123456; has_addr = 1'b1; length = 4'd2; read_write = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got_addr = 1'b0;
    for (int cyc = 0; cyc < 200 && !got_addr; cyc++) begin
      if (phase == 3'd3) got_addr = 1'b1;
      else @(negedge clk);
    end
    chk("reached_addr", got_addr, 1'b1);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_outputs", {cs_n, sclk, busy, phase}, {1'b1, 1'b0, 1'b0, 3'd0});
    @(negedge clk);
    rst_n = 1'b1;
    randomize_miso();
    run_txn(8'h03, 24'h00FF00, 1'b1, 3, 1'b1, 0, 1'b0);

    // Maximum length in both directions.
    for (int k = 0; k < 16; k++) tx_bytes[k] = 8'($urandom);
    run_txn(8'h02, 24'h7F0001, 1'b1, 15, 1'b0, 0, 1'b0);
    randomize_miso();
    run_txn(8'h03, 24'h000010, 1'b1, 15, 1'b1, 0, 1'b0);

    // Randomized transactions.
    for (int t = 0; t < 6; t++) begin
      randomize_miso();
      for (int k = 0; k < 16; k++) tx_bytes[k] = 8'($urandom);
      ra = 24'($urandom);
      run_txn(8'($urandom), ra, 1'($urandom), int'($urandom_range(0, 4)), 1'($urandom), 0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end
endmodule
